// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: runtime-programmable SPI serial clock and shift/sample strobe generator.
// Latency: Busy from the accepting edge t0; Sclk toggles at t0+k*(Div+1), k=1..2*Nbits; Done at t0+(2*Nbits+1)*(Div+1).
// Backpressure: none; Start is accepted only in IDLE, and a Start seen while Busy is dropped (not queued).
//
// Ports:
//   CLK, RSTn           clock (posedge) and asynchronous active-low reset
//   Start               transfer request, accepted only while idle
//   Div, Cpol, Cpha,    half-period minus one, idle clock level, clock phase and
//   Nbits               bit count; all latched on an accepted Start
//   Abort               synchronous cancel (present only when SPI_SCLK_ABORT_EN is defined)
//   Busy, Done          transfer in progress / one-cycle end-of-transfer pulse
//   Sclk                registered SPI clock
//   Shift_Stb           one-cycle pulse: present the next MOSI bit
//   Sample_Stb          one-cycle pulse: capture the MISO bit
//
// Optional feature macro: SPI_SCLK_ABORT_EN (adds the Abort port and cancel path).

module spi_sclk_gen #(
    parameter int   DIV_W    = 8,
    parameter int   NBITS_W  = 6,
    parameter logic RST_CPOL = 1'b0
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Start,
    input  logic [DIV_W-1:0]   Div,
    input  logic               Cpol,
    input  logic               Cpha,
    input  logic [NBITS_W-1:0] Nbits,
`ifdef SPI_SCLK_ABORT_EN
    input  logic               Abort,
`endif
    output logic               Busy,
    output logic               Done,
    output logic               Sclk,
    output logic               Shift_Stb,
    output logic               Sample_Stb
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

    localparam logic [DIV_W-1:0] HCNT_ONE = 1;
    localparam logic [NBITS_W:0] ECNT_ONE = 1;

    state_t               state, state_n;
    logic [DIV_W-1:0]     hcnt, hcnt_n;
    logic [NBITS_W:0]     ecnt, ecnt_n;     // Sclk toggles issued so far
    logic [DIV_W-1:0]     div_l;
    logic [NBITS_W-1:0]   nbits_l;
    logic                 cpol_l, cpha_l;
    logic                 latch;
    logic                 sclk_n, shift_n, sample_n, done_n;
    logic                 tc;
    logic [NBITS_W:0]     k;                // index of the toggle being issued
    logic [NBITS_W:0]     last_k;           // 2*Nbits_l

    assign tc     = (hcnt == div_l);
    assign k      = ecnt + ECNT_ONE;
    assign last_k = {nbits_l, 1'b0};
    assign Busy   = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            hcnt       <= '0;
            ecnt       <= '0;
            div_l      <= '0;
            nbits_l    <= '0;
            cpol_l     <= RST_CPOL;
            cpha_l     <= 1'b0;
            Sclk       <= RST_CPOL;
            Shift_Stb  <= 1'b0;
            Sample_Stb <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_n;
            hcnt       <= hcnt_n;
            ecnt       <= ecnt_n;
            Sclk       <= sclk_n;
            Shift_Stb  <= shift_n;
            Sample_Stb <= sample_n;
            Done       <= done_n;
            if (latch) begin
                div_l   <= Div;
                nbits_l <= Nbits;
                cpol_l  <= Cpol;
                cpha_l  <= Cpha;
            end
        end
    end

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        ecnt_n   = ecnt;
        sclk_n   = Sclk;
        shift_n  = 1'b0;
        sample_n = 1'b0;
        done_n   = 1'b0;
        latch    = 1'b0;

        case (state)
            IDLE: begin
                sclk_n = Cpol;
                if (Start) begin
                    latch  = 1'b1;
                    ecnt_n = '0;
                    if (Nbits == '0) begin
                        // Empty transfer: preload hcnt to the terminal value so
                        // HOLD ends on the very next edge (Done at t0+1).
                        hcnt_n  = Div;
                        state_n = HOLD;
                    end else begin
                        hcnt_n  = '0;
                        state_n = SETUP;
                        // CPHA=0: first MOSI bit must be valid before the leading edge.
                        shift_n = ~Cpha;
                    end
                end
            end
            SETUP: begin
                sclk_n = cpol_l;
                if (tc) begin
                    // End of setup half-period is also the first (leading) toggle.
                    hcnt_n  = '0;
                    sclk_n  = ~cpol_l;
                    ecnt_n  = ECNT_ONE;
                    state_n = RUN;
                    if (cpha_l) shift_n  = 1'b1;
                    else        sample_n = 1'b1;
                end else begin
                    hcnt_n = hcnt + HCNT_ONE;
                end
            end
            RUN: begin
                if (tc) begin
                    hcnt_n = '0;
                    sclk_n = ~Sclk;
                    ecnt_n = k;
                    if (k[0]) begin
                        // leading edge
                        if (cpha_l) shift_n  = 1'b1;
                        else        sample_n = 1'b1;
                    end else begin
                        // trailing edge; CPHA=0 has no bit to present after the last one
                        if (cpha_l)           sample_n = 1'b1;
                        else if (k != last_k) shift_n  = 1'b1;
                    end
                    if (k == last_k) state_n = HOLD;
                end else begin
                    hcnt_n = hcnt + HCNT_ONE;
                end
            end
            HOLD: begin
                sclk_n = cpol_l;
                if (tc) begin
                    hcnt_n  = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    hcnt_n = hcnt + HCNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                hcnt_n  = '0;
                ecnt_n  = '0;
            end
        endcase

`ifdef SPI_SCLK_ABORT_EN
        // Cancel wins over any terminal count in the same cycle.
        if (Abort && state != IDLE) begin
            state_n  = IDLE;
            hcnt_n   = '0;
            ecnt_n   = '0;
            sclk_n   = cpol_l;
            shift_n  = 1'b0;
            sample_n = 1'b0;
            done_n   = 1'b0;
        end
`endif
    end

endmodule
